// File: rtl/mem_arbiter_if.sv
// Bundle of client handshakes, shared read data and memory-side port for mem_arbiter.
// slave: the arbiter's view. master: the clients/memory side's view.
interface mem_arbiter_if #(
   parameter int unsigned MEM_SIZE = 6,
   parameter int unsigned DATA_W   = 10
);
   localparam int unsigned ADDR_SIZE = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   logic                 a_req;
   logic                 a_we;
   logic [ADDR_SIZE-1:0] a_addr;
   logic [DATA_W-1:0]    a_wdata;
   logic                 a_gnt;
   logic                 a_rvalid;

   logic                 b_req;
   logic                 b_we;
   logic [ADDR_SIZE-1:0] b_addr;
   logic [DATA_W-1:0]    b_wdata;
   logic                 b_gnt;
   logic                 b_rvalid;

   logic [DATA_W-1:0]    rdata;
   logic                 err;

   logic                 mem_write_flag;
   logic [DATA_W-1:0]    mem_data_in;
   logic [ADDR_SIZE-1:0] mem_addr_w;
   logic                 mem_read_flag;
   logic [ADDR_SIZE-1:0] mem_addr_r;
   logic [DATA_W-1:0]    mem_data_out;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_data_out,
      output a_gnt, a_rvalid, b_gnt, b_rvalid,
      output rdata, err,
      output mem_write_flag, mem_data_in, mem_addr_w, mem_read_flag, mem_addr_r
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_data_out,
      input  a_gnt, a_rvalid, b_gnt, b_rvalid,
      input  rdata, err,
      input  mem_write_flag, mem_data_in, mem_addr_w, mem_read_flag, mem_addr_r
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single memory block.
// Pipeline: grant (T, combinational) -> memory issue (T+1) -> read return (T+2).
// Optional feature macro: MEM_ARB_ADDR_CHECK_EN enables the out-of-range address
// check (no memory op, err pulse, zero read data); when undefined err is tied 0.
module mem_arbiter #(
   parameter int unsigned MEM_SIZE = 6,
   parameter int unsigned DATA_W   = 10
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned ADDR_SIZE = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   owner_t               prio;
   logic                 gnt_a;
   logic                 gnt_b;
   logic                 sel_we;
   logic [ADDR_SIZE-1:0] sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic                 sel_oor;

   logic                 write_flag;
   logic [DATA_W-1:0]    data_in;
   logic [ADDR_SIZE-1:0] addr_w;
   logic                 read_flag;
   logic [ADDR_SIZE-1:0] addr_r;
   logic                 err_q;
   logic                 iss_read;
   owner_t               iss_owner;
   logic                 iss_oor;

   logic                 rvalid_a;
   logic                 rvalid_b;
   logic                 ret_err;
   logic [DATA_W-1:0]    rdata_hold;
   logic [DATA_W-1:0]    ret_data;

   // Grant selection: lone requester wins, contention resolved by priority holder
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         if (bus.a_req && (!bus.b_req || prio == OWN_A)) begin
            gnt_a = 1'b1;
         end else if (bus.b_req) begin
            gnt_b = 1'b1;
         end
      end
   end

   // Mux the granted client's request onto the issue path
   always_comb begin
      sel_we    = gnt_b ? bus.b_we    : bus.a_we;
      sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
      sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
`ifdef MEM_ARB_ADDR_CHECK_EN
      sel_oor   = (32'(sel_addr) >= 32'(MEM_SIZE));
`else
      sel_oor   = 1'b0;
`endif
   end

   // Priority pointer: passes to the other client only when its holder is granted
   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= OWN_A;
      end else if (gnt_a && prio == OWN_A) begin
         prio <= OWN_B;
      end else if (gnt_b && prio == OWN_B) begin
         prio <= OWN_A;
      end
   end

   // Issue stage: one-cycle memory op pulses; address/data registers hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         write_flag <= 1'b0;
         data_in    <= '0;
         addr_w     <= '0;
         read_flag  <= 1'b0;
         addr_r     <= '0;
         err_q      <= 1'b0;
         iss_read   <= 1'b0;
         iss_owner  <= OWN_A;
         iss_oor    <= 1'b0;
      end else begin
         write_flag <= 1'b0;
         read_flag  <= 1'b0;
         err_q      <= 1'b0;
         iss_read   <= 1'b0;
         if (gnt_a || gnt_b) begin
            err_q     <= sel_oor;
            iss_read  <= !sel_we;
            iss_owner <= gnt_b ? OWN_B : OWN_A;
            iss_oor   <= sel_oor;
            if (!sel_oor) begin
               if (sel_we) begin
                  write_flag <= 1'b1;
                  addr_w     <= sel_addr;
                  data_in    <= sel_wdata;
               end else begin
                  read_flag  <= 1'b1;
                  addr_r     <= sel_addr;
               end
            end
         end
      end
   end

   // Return stage: owner tag travels with the read so interleaved reads stay ordered
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_a   <= 1'b0;
         rvalid_b   <= 1'b0;
         ret_err    <= 1'b0;
         rdata_hold <= '0;
      end else begin
         rvalid_a <= iss_read && (iss_owner == OWN_A);
         rvalid_b <= iss_read && (iss_owner == OWN_B);
         ret_err  <= iss_oor;
         if (rvalid_a || rvalid_b) begin
            rdata_hold <= ret_data;
         end
      end
   end

   // Memory output is already registered; pass it through in the return cycle only
   always_comb begin
      ret_data = ret_err ? '0 : bus.mem_data_out;
   end

   assign bus.a_gnt          = gnt_a;
   assign bus.b_gnt          = gnt_b;
   assign bus.a_rvalid       = rvalid_a;
   assign bus.b_rvalid       = rvalid_b;
   assign bus.rdata          = (rvalid_a || rvalid_b) ? ret_data : rdata_hold;
   assign bus.err            = err_q;
   assign bus.mem_write_flag = write_flag;
   assign bus.mem_data_in    = data_in;
   assign bus.mem_addr_w     = addr_w;
   assign bus.mem_read_flag  = read_flag;
   assign bus.mem_addr_r     = addr_r;

endmodule
